// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: redirect/stall controls and memory write port in,
// fetched instruction out. The fetch unit sits on the slave side.
interface instruction_fetch_if #(
  parameter int ADDR_W = 6
);
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              jump_taken;
  logic [25:0]       jump_index;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       data_out;
  logic [31:0]       fetch_pc;
  logic              fetch_valid;

  modport master (
    output stall, branch_taken, branch_target, jump_taken, jump_index,
           imem_we, imem_addr, imem_wdata,
    input  data_out, fetch_pc, fetch_valid
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump_taken, jump_index,
           imem_we, imem_addr, imem_wdata,
    output data_out, fetch_pc, fetch_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: byte-addressed PC, word-addressed instruction
// memory, one instruction per clock, one bubble per branch/jump redirect.
module instruction_fetch #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic               clock,
  input logic               reset_n,
  instruction_fetch_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] data_out_reg, data_out_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        fetch_valid_reg, fetch_valid_next;

  logic [31:0] mem [MEM_DEPTH];

  // Upper PC bits are ignored for lookup, so the index wraps modulo MEM_DEPTH.
  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       jump_target;
  logic [31:0]       branch_dest;
  logic              redirect;

  assign fetch_idx   = pc_reg[ADDR_W+1:2];
  assign jump_target = {fetch_pc_reg[31:28], bus.jump_index, 2'b00};
  assign branch_dest = bus.branch_target & 32'hFFFF_FFFC;
  assign redirect    = bus.jump_taken | bus.branch_taken;

  // Memory write port; independent of reset, stall and redirect. A fetch of
  // the same word on this edge sees the pre-write contents.
  always_ff @(posedge clock) begin
    if (bus.imem_we) begin
      mem[bus.imem_addr] <= bus.imem_wdata;
    end
  end

  // State register and fetch pipeline registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      data_out_reg    <= 32'h0;
      fetch_pc_reg    <= 32'h0;
      fetch_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      data_out_reg    <= data_out_next;
      fetch_pc_reg    <= fetch_pc_next;
      fetch_valid_reg <= fetch_valid_next;
    end
  end

  // Next-state and datapath: redirect beats stall, jump beats branch.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    data_out_next    = data_out_reg;
    fetch_pc_next    = fetch_pc_reg;
    fetch_valid_next = fetch_valid_reg;

    if (redirect) begin
      pc_next          = bus.jump_taken ? jump_target : branch_dest;
      data_out_next    = 32'h0;
      fetch_pc_next    = 32'h0;
      fetch_valid_next = 1'b0;
    end else if (!bus.stall) begin
      data_out_next    = mem[fetch_idx];
      fetch_pc_next    = pc_reg;
      fetch_valid_next = 1'b1;
      pc_next          = pc_reg + 32'd4;
    end

    unique case (state_reg)
      BOOT:    if (redirect || !bus.stall) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  assign bus.data_out    = data_out_reg;
  assign bus.fetch_pc    = fetch_pc_reg;
  assign bus.fetch_valid = fetch_valid_reg;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized
// traffic, all checked against a rule-level reference model.
module tb_instruction_fetch;
  localparam int MEM_DEPTH = 64;
  localparam int AW        = 6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  instruction_fetch_if #(.ADDR_W(AW)) bus ();

  instruction_fetch #(.MEM_DEPTH(MEM_DEPTH), .RESET_PC(32'h0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state
  logic [31:0] ref_mem [MEM_DEPTH];
  logic [31:0] ref_pc, ref_data, ref_fpc;
  logic        ref_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    ref_pc    = 32'h0;
    ref_data  = 32'h0;
    ref_fpc   = 32'h0;
    ref_valid = 1'b0;
  endtask

  // One clock: drive inputs, apply reference rules at the edge, compare at
  // the following falling edge.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jt, input logic [25:0] ji,
                      input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                      input string tag);
    logic [31:0] n_pc, n_data, n_fpc;
    logic        n_valid;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump_taken    = jt;
    bus.jump_index    = ji;
    bus.imem_we       = we;
    bus.imem_addr     = wa;
    bus.imem_wdata    = wd;
    @(posedge clock);
    n_pc = ref_pc; n_data = ref_data; n_fpc = ref_fpc; n_valid = ref_valid;
    if (reset_n) begin
      if (jt || br) begin
        n_pc    = jt ? ((ref_fpc & 32'hF000_0000) + (32'(ji) * 4)) : (bt / 4) * 4;
        n_data  = 32'h0;
        n_fpc   = 32'h0;
        n_valid = 1'b0;
      end else if (!st) begin
        n_data  = ref_mem[(ref_pc / 4) % MEM_DEPTH];
        n_fpc   = ref_pc;
        n_valid = 1'b1;
        n_pc    = ref_pc + 32'd4;
      end
    end
    ref_pc = n_pc; ref_data = n_data; ref_fpc = n_fpc; ref_valid = n_valid;
    if (we) ref_mem[wa] = wd;
    @(negedge clock);
    $display("%s: st=%b br=%b jt=%b -> pc=%h data=%h valid=%b",
             tag, st, br, jt, bus.fetch_pc, bus.data_out, bus.fetch_valid);
    check({tag, ".data"},  bus.data_out, ref_data);
    check({tag, ".pc"},    bus.fetch_pc, ref_fpc);
    check({tag, ".valid"}, 32'(bus.fetch_valid), 32'(ref_valid));
  endtask

  task automatic nop(input string tag);
    step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, '0, 32'h0, tag);
  endtask

  task automatic branch(input logic [31:0] bt, input string tag);
    step(1'b0, 1'b1, bt, 1'b0, 26'h0, 1'b0, '0, 32'h0, tag);
  endtask

  logic [31:0] boot_words [4];

  initial begin
    boot_words[0] = 32'h44020005;
    boot_words[1] = 32'h04011000;
    boot_words[2] = 32'h11111111;
    boot_words[3] = 32'h22222222;
    ref_reset();

    // Load the whole memory while reset is held.
    for (int i = 0; i < MEM_DEPTH; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, AW'(i),
           (i < 4) ? boot_words[i] : $urandom, "load");
    end
    check("reset.data",  bus.data_out, 32'h0);
    check("reset.pc",    bus.fetch_pc, 32'h0);
    check("reset.valid", 32'(bus.fetch_valid), 32'h0);

    // Boot and sequential fetch
    reset_n = 1'b1;
    nop("boot0");
    check("boot0.word", bus.data_out, 32'h44020005);
    nop("boot1");
    check("boot1.word", bus.data_out, 32'h04011000);

    // Stall holds everything for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, '0, 32'h0, "stall");
      check("stall.hold", bus.fetch_pc, 32'h4);
    end
    nop("after_stall");
    check("after_stall.word", bus.data_out, 32'h11111111);
    check("after_stall.pc",   bus.fetch_pc, 32'h8);

    // Branch with misaligned target: bubble, then fetch from 0x10
    branch(32'h0000_0011, "branch");
    check("branch.bubble", 32'(bus.fetch_valid), 32'h0);
    nop("branch_tgt");
    check("branch_tgt.pc", bus.fetch_pc, 32'h10);

    // Jump beats branch and overrides stall
    step(1'b1, 1'b1, 32'h20, 1'b1, 26'h2, 1'b0, '0, 32'h0, "jump_prio");
    nop("jump_tgt");
    check("jump_tgt.pc",   bus.fetch_pc, 32'h8);
    check("jump_tgt.word", bus.data_out, 32'h11111111);

    // Wrap-around past the last word
    branch(32'h0000_00FC, "wrap_br");
    nop("wrap_fc");
    check("wrap_fc.pc", bus.fetch_pc, 32'hFC);
    nop("wrap_100");
    check("wrap_100.pc",   bus.fetch_pc, 32'h100);
    check("wrap_100.word", bus.data_out, 32'h44020005);

    // Write collision: same-edge fetch returns old word
    branch(32'h0, "coll_br");
    step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, '0, 32'hDEADBEEF, "coll_fetch");
    check("coll_fetch.old", bus.data_out, 32'h44020005);
    branch(32'h0, "coll_br2");
    nop("coll_new");
    check("coll_new.word", bus.data_out, 32'hDEADBEEF);

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    check("async.data",  bus.data_out, 32'h0);
    check("async.pc",    bus.fetch_pc, 32'h0);
    check("async.valid", 32'(bus.fetch_valid), 32'h0);
    ref_reset();
    nop("in_reset");
    reset_n = 1'b1;
    nop("reboot");
    check("reboot.word", bus.data_out, 32'hDEADBEEF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 11) == 0, 26'($urandom),
           $urandom_range(0, 5) == 0, AW'($urandom), $urandom, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
